// File: rtl/sram_copy_pkg.sv
// Shared definitions for the SRAM block-copy initiator.
package sram_copy_pkg;

  localparam int CPY_ADDR_W = 13;  // word address width of the SRAM port
  localparam int CPY_DATA_W = 32;  // SRAM word width
  localparam int CPY_DEPTH  = 4;   // words per chunk

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    FIN
  } state_t;

endpackage

// File: rtl/sram_copy_buf.sv
// Chunk buffer: DEPTH words filled in order by captured read data and
// drained in order for the write phase. Pointers restart for every chunk.
module sram_copy_buf #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_inc,
  output logic [DATA_W-1:0] rd_data
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;

  // Pointer bookkeeping; clear restarts both at the top of each chunk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_inc) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // One storage register per slot, loaded when the write pointer selects it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (wr_en && wr_ptr_reg == PW'(gi)) mem_reg[gi] <= wr_data;
    end
  end

  // A one-word chunk captures and reads the same slot on the same edge,
  // so the incoming word is forwarded straight through.
  assign rd_data = (wr_en && wr_ptr_reg == rd_ptr_reg) ? wr_data : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/sram_copy_master.sv
// Avalon-MM initiator copying a block of words inside the dual-port SRAM,
// one chunk at a time: read up to DEPTH words, then write them back out.
module sram_copy_master
  import sram_copy_pkg::*;
#(
  parameter int ADDR_W = CPY_ADDR_W,
  parameter int DATA_W = CPY_DATA_W,
  parameter int DEPTH  = CPY_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  output logic [3:0]        m_byteenable,
  output logic              m_clken,
  input  logic [DATA_W-1:0] m_readdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;      // holds 0..DEPTH
  localparam int LW = ADDR_W + 1;  // holds 0..2^ADDR_W
  localparam int SW = ADDR_W + 2;  // range-check sums never wrap
  localparam logic [SW-1:0] SPAN = {2'b01, {ADDR_W{1'b0}}};

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] src_reg, src_next;
  logic [ADDR_W-1:0] dst_reg, dst_next;
  logic [LW-1:0]     remaining_reg, remaining_next, remaining_left;
  logic [CW-1:0]     chunk_reg, chunk_next;
  logic [CW-1:0]     idx_reg, idx_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              cs_reg, cs_next;
  logic              write_reg, write_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              rd_valid_reg;
  logic              buf_clear, buf_rd_inc;
  logic [DATA_W-1:0] buf_rd_data;
  logic [SW-1:0]     src_end, dst_end;

  function automatic logic [CW-1:0] chunk_of(input logic [LW-1:0] n);
    if (n >= LW'(DEPTH)) return CW'(DEPTH);
    return n[CW-1:0];
  endfunction

  sram_copy_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clear   (buf_clear),
    .wr_en   (rd_valid_reg),
    .wr_data (m_readdata),
    .rd_inc  (buf_rd_inc),
    .rd_data (buf_rd_data)
  );

  // Next state plus the bus access to present during the coming cycle.
  always_comb begin
    state_next     = state_reg;
    src_next       = src_reg;
    dst_next       = dst_reg;
    remaining_next = remaining_reg;
    chunk_next     = chunk_reg;
    idx_next       = idx_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    err_next       = err_reg;
    addr_next      = addr_reg;
    cs_next        = 1'b0;
    write_next     = 1'b0;
    wdata_next     = wdata_reg;
    buf_clear      = 1'b0;
    buf_rd_inc     = 1'b0;
    remaining_left = remaining_reg - LW'(chunk_reg);
    src_end        = {2'b00, src_addr} + {1'b0, len};
    dst_end        = {2'b00, dst_addr} + {1'b0, len};

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (src_end > SPAN || dst_end > SPAN) begin
            state_next = FIN;
            err_next   = 1'b1;
          end else if (len == '0) begin
            state_next = FIN;
            err_next   = 1'b0;
          end else begin
            state_next     = READ;
            busy_next      = 1'b1;
            err_next       = 1'b0;
            remaining_next = len;
            chunk_next     = chunk_of(len);
            dst_next       = dst_addr;
            addr_next      = src_addr;
            cs_next        = 1'b1;
            src_next       = src_addr + 1'b1;
            idx_next       = CW'(1);
            buf_clear      = 1'b1;
          end
        end
      end
      READ: begin
        if (abort) begin
          state_next = FIN;
          err_next   = 1'b1;
        end else if (idx_reg < chunk_reg) begin
          addr_next = src_reg;
          cs_next   = 1'b1;
          src_next  = src_reg + 1'b1;
          idx_next  = idx_reg + 1'b1;
        end else begin
          state_next = DRAIN;
          idx_next   = '0;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_next = FIN;
          err_next   = 1'b1;
        end else begin
          state_next = WRITE;
          addr_next  = dst_reg;
          cs_next    = 1'b1;
          write_next = 1'b1;
          wdata_next = buf_rd_data;
          buf_rd_inc = 1'b1;
          dst_next   = dst_reg + 1'b1;
          idx_next   = CW'(1);
        end
      end
      WRITE: begin
        if (abort) begin
          state_next = FIN;
          err_next   = 1'b1;
        end else if (idx_reg < chunk_reg) begin
          addr_next  = dst_reg;
          cs_next    = 1'b1;
          write_next = 1'b1;
          wdata_next = buf_rd_data;
          buf_rd_inc = 1'b1;
          dst_next   = dst_reg + 1'b1;
          idx_next   = idx_reg + 1'b1;
        end else begin
          remaining_next = remaining_left;
          if (remaining_left != '0) begin
            state_next = READ;
            chunk_next = chunk_of(remaining_left);
            addr_next  = src_reg;
            cs_next    = 1'b1;
            src_next   = src_reg + 1'b1;
            idx_next   = CW'(1);
            buf_clear  = 1'b1;
          end else begin
            state_next = FIN;
          end
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Every path into FIN ends the copy: pulse done, drop busy, quiet the bus.
    if (state_next == FIN) begin
      done_next  = 1'b1;
      busy_next  = 1'b0;
      cs_next    = 1'b0;
      write_next = 1'b0;
    end
  end

  // State, counters and registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      src_reg       <= '0;
      dst_reg       <= '0;
      remaining_reg <= '0;
      chunk_reg     <= '0;
      idx_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      addr_reg      <= '0;
      cs_reg        <= 1'b0;
      write_reg     <= 1'b0;
      wdata_reg     <= '0;
      rd_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      src_reg       <= src_next;
      dst_reg       <= dst_next;
      remaining_reg <= remaining_next;
      chunk_reg     <= chunk_next;
      idx_reg       <= idx_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      addr_reg      <= addr_next;
      cs_reg        <= cs_next;
      write_reg     <= write_next;
      wdata_reg     <= wdata_next;
      rd_valid_reg  <= cs_reg & ~write_reg;  // readdata arrives next cycle
    end
  end

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign err          = err_reg;
  assign m_address    = addr_reg;
  assign m_chipselect = cs_reg;
  assign m_write      = write_reg;
  assign m_writedata  = wdata_reg;
  assign m_byteenable = 4'hF;
  assign m_clken      = 1'b1;

endmodule
